// File: rtl/sipo_decoder.sv
// rtl/sipo_decoder.sv - serial-in parallel-out deserialiser framed by a DT strobe
module sipo_decoder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             DT,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] parallel_Out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT    = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] word_n;
  logic             valid_n, busy_n, fe_n, ov_n;
  logic             last_bit;

  assign last_bit = (state == SHIFT) && DT && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sreg         <= '0;
      cnt          <= '0;
      parallel_Out <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      sreg         <= sreg_n;
      cnt          <= cnt_n;
      parallel_Out <= word_n;
      out_valid    <= valid_n;
      busy         <= busy_n;
      frame_err    <= fe_n;
      overrun      <= ov_n;
    end
  end

  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:     state_n = DT ? SHIFT : IDLE;
      SHIFT: begin
        if (!DT)          state_n = IDLE;
        else if (last_bit) state_n = WAIT_LOW;
        else              state_n = SHIFT;
      end
      WAIT_LOW: state_n = DT ? WAIT_LOW : IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Completing word bypasses sreg so parallel_Out is loaded on the capturing edge.
  always_comb begin
    sreg_n  = sreg;
    cnt_n   = cnt;
    word_n  = parallel_Out;
    valid_n = out_valid;
    fe_n    = 1'b0;
    ov_n    = 1'b0;
    if (out_valid && rd_ack) valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (DT) begin
          sreg_n[0] = serial_in;
          cnt_n     = CW'(1);
        end else begin
          cnt_n = '0;
        end
      end
      SHIFT: begin
        if (!DT) begin
          cnt_n = '0;
          fe_n  = 1'b1;
        end else if (last_bit) begin
          word_n  = {serial_in, sreg[WIDTH-2:0]};
          valid_n = 1'b1;
          ov_n    = out_valid && !rd_ack;
          cnt_n   = '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CW'(i)) sreg_n[i] = serial_in;
          end
          cnt_n = cnt + CW'(1);
        end
      end
      default: cnt_n = '0;
    endcase
    busy_n = (state_n == SHIFT) || (state_n == WAIT_LOW);
  end

endmodule

// File: tb/tb_sipo_decoder.sv
// tb/tb_sipo_decoder.sv - scoreboard bench for sipo_decoder at WIDTH 8 and 32
module tb_sipo_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        sin8 = 1'b0, dt8 = 1'b0, ack8 = 1'b0;
  logic [7:0]  po8;
  logic        ov8_valid, busy8, fe8, orun8;
  logic        sin32 = 1'b0, dt32 = 1'b0, ack32 = 1'b0;
  logic [31:0] po32;
  logic        ov32_valid, busy32, fe32, orun32;

  sipo_decoder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .serial_in(sin8), .DT(dt8), .rd_ack(ack8),
    .parallel_Out(po8), .out_valid(ov8_valid), .busy(busy8),
    .frame_err(fe8), .overrun(orun8)
  );

  sipo_decoder #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .serial_in(sin32), .DT(dt32), .rd_ack(ack32),
    .parallel_Out(po32), .out_valid(ov32_valid), .busy(busy32),
    .frame_err(fe32), .overrun(orun32)
  );

  typedef struct packed {
    logic [7:0] word;
    logic       ov;
  } exp8_t;

  exp8_t       q8[$];
  logic [31:0] q32[$];
  int n_checks = 0;
  int n_fail   = 0;
  int fe_seen  = 0;
  int exp_fe   = 0;
  logic model_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a word load is a rise of out_valid or a change of the held word.
  logic       prev_valid8 = 1'b0;
  logic [7:0] prev_word8 = 8'h0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid8 = 1'b0;
      prev_word8  = 8'h0;
    end else begin
      exp8_t e;
      if (fe8 && orun8) check("fe_ov_exclusive", 64'(fe8 & orun8), 64'd0);
      if (fe8) fe_seen++;
      if (ov8_valid && (!prev_valid8 || po8 != prev_word8)) begin
        if (q8.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", po8);
        end else begin
          e = q8.pop_front();
          check("word8", 64'(po8), 64'(e.word));
          check("overrun8", 64'(orun8), 64'(e.ov));
        end
      end else if (orun8) begin
        check("stray_overrun8", 64'(orun8), 64'd0);
      end
      prev_valid8 = ov8_valid;
      prev_word8  = po8;
    end
  end

  logic prev_valid32 = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid32 = 1'b0;
    end else begin
      if (fe32) check("frame_err32", 64'(fe32), 64'd0);
      if (ov32_valid && !prev_valid32) begin
        if (q32.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word32: got %0h expected none", po32);
        end else begin
          check("word32", 64'(po32), 64'(q32.pop_front()));
        end
      end
      prev_valid32 = ov32_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame8(input logic [7:0] w, input int nbits, input logic ack_last);
    if (nbits == 8) begin
      q8.push_back('{word: w, ov: model_valid && !ack_last});
      model_valid = 1'b1;
    end else begin
      exp_fe++;
    end
    for (int i = 0; i < nbits; i++) begin
      dt8  = 1'b1;
      sin8 = w[i];
      ack8 = (i == nbits - 1) ? ack_last : 1'b0;
      tick();
    end
    ack8 = 1'b0;
    dt8  = 1'b0;
    sin8 = 1'b0;
    tick();
  endtask

  task automatic ack_pulse();
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    model_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_po"}, 64'(po8), 64'd0);
    check({tag, "_valid"}, 64'(ov8_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy8), 64'd0);
    check({tag, "_fe"}, 64'(fe8), 64'd0);
    check({tag, "_ov"}, 64'(orun8), 64'd0);
  endtask

  initial begin
    logic [31:0] w32;
    logic [7:0]  w8;
    int          fe_before;
    w32 = 32'hA5A5_0F01;

    #2;
    check_all_zero("reset");
    check("reset_po32", 64'(po32), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("idle");

    // 32-bit word, LSB first
    for (int i = 0; i < 32; i++) begin
      dt32  = 1'b1;
      sin32 = w32[i];
      if (i == 31) q32.push_back(w32);
      tick();
      if (i == 30) check("valid32_early", 64'(ov32_valid), 64'd0);
    end
    check("valid32_after_bit31", 64'(ov32_valid), 64'd1);
    check("po32", 64'(po32), 64'(w32));
    dt32 = 1'b0;
    tick();

    // short frame: five bits then DT low
    frame8(8'h1F, 5, 1'b0);
    tick();
    check("short_fe_count", 64'(fe_seen), 64'(exp_fe));
    check_all_zero("short");

    // two frames without ack: overrun on the second
    frame8(8'h3C, 8, 1'b0);
    frame8(8'hC3, 8, 1'b0);
    tick();
    check("ovr_po", 64'(po8), 64'hC3);
    check("ovr_valid", 64'(ov8_valid), 64'd1);
    ack_pulse();
    tick();
    check("ack_clears_valid", 64'(ov8_valid), 64'd0);

    // completion coincident with rd_ack: no overrun
    frame8(8'h96, 8, 1'b0);
    frame8(8'h69, 8, 1'b1);
    tick();
    check("sameack_po", 64'(po8), 64'h69);
    check("sameack_valid", 64'(ov8_valid), 64'd1);
    ack_pulse();

    // DT held for 20 cycles: one word only, then WAIT_LOW
    w8 = 8'hB4;
    fe_before = fe_seen;
    q8.push_back('{word: w8, ov: 1'b0});
    model_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dt8  = 1'b1;
      sin8 = (i < 8) ? w8[i] : 1'b1;
      tick();
      if (i == 12) check("waitlow_busy", 64'(busy8), 64'd1);
    end
    check("waitlow_busy_end", 64'(busy8), 64'd1);
    dt8 = 1'b0;
    tick();
    check("waitlow_release_busy", 64'(busy8), 64'd0);
    check("waitlow_no_fe", 64'(fe_seen), 64'(fe_before));
    check("waitlow_po", 64'(po8), 64'hB4);
    ack_pulse();

    // reset mid-frame at bit 4, released three cycles later
    w8 = 8'h5A;
    fe_before = fe_seen;
    for (int i = 0; i < 4; i++) begin
      dt8  = 1'b1;
      sin8 = w8[i];
      tick();
    end
    sin8 = w8[4];
    #2 reset = 1'b0;
    dt8 = 1'b0;
    model_valid = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("postreset");
    check("postreset_no_fe", 64'(fe_seen), 64'(fe_before));
    frame8(8'h5A, 8, 1'b0);
    tick();
    check("postreset_po", 64'(po8), 64'h5A);
    check("postreset_valid", 64'(ov8_valid), 64'd1);

    for (int i = 0; i < 20 && (q8.size() != 0 || q32.size() != 0); i++) tick();
    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("fe_total", 64'(fe_seen), 64'(exp_fe));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_decoder.md
SIPO_DECODER -- requirements
Module: sipo_decoder

Interface
REQ-001 Parameter: WIDTH, default 32, deserialised word width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately, release synchronous to clk.
REQ-004 serial_in  input  1  serial data bit, LSB first, sampled on posedge clk while DT high.
REQ-005 DT  input  1  data-transmit frame strobe from upstream serialiser; high for the duration of one word.
REQ-006 rd_ack  input  1  consumer acknowledge; clears out_valid.
REQ-007 parallel_Out  output  WIDTH  last completed word; held stable until the next completed word.
REQ-008 out_valid  output  1  level; high while parallel_Out holds an unacknowledged word.
REQ-009 busy  output  1  high in SHIFT and WAIT_LOW states.
REQ-010 frame_err  output  1  one-cycle pulse; frame ended before WIDTH bits.
REQ-011 overrun  output  1  one-cycle pulse; unacknowledged word overwritten.

Function
REQ-012 FSM states: IDLE, SHIFT, WAIT_LOW; encoded in 2 bits; unused encoding returns to IDLE next cycle.
REQ-013 Internal shift register sreg[WIDTH-1:0]; bit counter cnt of width clog2(WIDTH+1), range 0..WIDTH.
REQ-014 IDLE: DT=1 at posedge -> sreg[0]<=serial_in, cnt<=1, go SHIFT; DT=0 -> stay, cnt held 0.
REQ-015 SHIFT with DT=1: sreg[cnt]<=serial_in, cnt<=cnt+1 (bit k of frame lands in sreg[k]).
REQ-016 On the posedge capturing bit WIDTH-1: the registered parallel_Out takes the full word (sreg with captured bit inserted) on that same edge; out_valid<=1; cnt<=0; go WAIT_LOW. Latency: word visible on parallel_Out the cycle after the last bit is sampled.
REQ-017 SHIFT with DT=0 (cnt<WIDTH): discard partial word, frame_err pulse 1 cycle, cnt<=0, go IDLE; parallel_Out and out_valid unchanged.
REQ-018 WAIT_LOW: ignore serial_in; DT=0 -> IDLE; DT=1 -> stay (no second word until DT falls and rises again).
REQ-019 WIDTH=1-bit frame special case not supported (WIDTH>=2 per REQ-001).
REQ-020 rd_ack=1 with out_valid=1 -> out_valid<=0 next cycle; rd_ack with out_valid=0 ignored.
REQ-021 Word completion while out_valid=1 and rd_ack=0: parallel_Out overwritten, out_valid stays 1, overrun pulse 1 cycle.
REQ-022 Word completion and rd_ack=1 in same cycle: new word loaded, out_valid stays 1, no overrun.
REQ-023 frame_err and overrun never asserted in the same cycle; each is registered, never combinational from inputs.
REQ-024 busy is a registered decode of state; high exactly while state is SHIFT or WAIT_LOW.

Reset
REQ-025 reset low: state=IDLE, cnt=0, sreg=0, parallel_Out=0, out_valid=0, busy=0, frame_err=0, overrun=0.
REQ-026 reset asserted mid-frame aborts the frame with no frame_err pulse; first frame after release starts only on a DT=1 sampled in IDLE.

Verification
REQ-027 WIDTH=32, DT high 32 cycles, serial_in = LSB-first bits of 0xA5A5_0F01 -> parallel_Out=0xA5A5_0F01, out_valid=1 one cycle after bit 31, frame_err=0.
REQ-028 WIDTH=8, DT high 5 cycles then low -> frame_err one pulse, out_valid=0, parallel_Out=0x00, state IDLE.
REQ-029 WIDTH=8, two frames 0x3C then 0xC3, no rd_ack -> overrun one pulse at second completion, parallel_Out=0xC3, out_valid=1.
REQ-030 WIDTH=8, second frame completes in same cycle as rd_ack -> parallel_Out=new word, out_valid=1, overrun=0.
REQ-031 WIDTH=8, DT held high 20 cycles -> exactly one word captured (bits 0..7), state WAIT_LOW until DT falls, no frame_err.
REQ-032 reset low at bit 4 of a frame, released 3 cycles later with DT low -> all outputs 0, no frame_err, next full frame 0x5A captured correctly.
